uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
UART transmitter placed directly downstream of the TX fifo. It pulls bytes from the fifo read port and serialises each one as an 8N1 frame on serial_out: start bit, 8 data bits LSB-first, one stop bit. It accounts for the fifo's registered read data, which is valid one cycle after rd_en. It is the final stage of the CPU-to-host debug/console path.

Parameters:
CLOCK_FREQ, 100_000_000, clk frequency in Hz
BAUD_RATE, 115_200, serial bit rate
DATA_WIDTH, 8, bits per frame payload; must match fifo DATA_WIDTH
CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (derived, localparam), clk cycles per serial bit; must be >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fifo_empty  in  1  fifo empty flag
fifo_dout  in  DATA_WIDTH  fifo registered read data; valid the cycle after fifo_rd_en
fifo_rd_en  out  1  read request to fifo; single-cycle pulse
serial_out  out  1  UART TX line; idle high
tx_busy  out  1  high from read request through end of stop bit

Behaviour:
- Reset values: serial_out=1, fifo_rd_en=0, tx_busy=0, state=IDLE, bit/baud counters=0, shift register=0.
- rst has priority in every state. Reset mid-frame drives serial_out=1 on the next cycle and drops the byte in flight; no partial-frame recovery.
- FSM states: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If !fifo_empty: fifo_rd_en=1 for this cycle only (combinational, state==IDLE && !fifo_empty), then go to FETCH.
  - If fifo_empty: stay in IDLE.
- FETCH: exactly 1 cycle.
  - fifo_rd_en=0, tx_busy=1, serial_out=1.
  - fifo_dout is valid this cycle; capture it into the shift register at the end of the cycle.
  - Clear baud and bit counters; go to START.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: serial_out = shift_reg[0].
  - Every CLKS_PER_BIT cycles: shift right by 1 and increment bit_cnt.
  - After DATA_WIDTH bits, go to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- fifo_rd_en is never asserted outside IDLE, and never while fifo_empty=1. This gives at most one outstanding read.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0; the wrap is the bit_done tick.
  - Held at 0 in IDLE/FETCH.
- bit_cnt: width $clog2(DATA_WIDTH)+1, cleared in FETCH.
- serial_out is driven from a register (glitch-free). Every bit lasts exactly CLKS_PER_BIT cycles.
- Back-to-back: if the fifo is non-empty at STOP exit, the next frame's start bit begins 2 cycles later (IDLE + FETCH). Inter-frame idle-high gap is exactly 2 cycles.
- Latency: fifo_empty falling to serial_out falling = 2 cycles (IDLE cycle with rd_en, then FETCH).
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- fifo_empty rising during a frame has no effect on the current frame.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, FETCH, START, DATA, STOP)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - default DATA_WIDTH=8
- Sub-module uart_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst, en; output bit_done pulse. The future uart_rx reuses it.
- The FSM and shift register stay in uart_tx_fifo_drain.

Test Plan:
- All tests use CLOCK_FREQ=100, BAUD_RATE=10, so CLKS_PER_BIT=10.
- Reset idle: hold rst 3 cycles with fifo_empty=1 -> serial_out=1, fifo_rd_en=0, tx_busy=0 throughout; no rd_en for 50 cycles after release.
- Single byte: fifo model holds 8'hA5; release empty -> one rd_en pulse; serial_out falls 2 cycles later; line reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_busy falls after 100 cycles of frame.
- Back-to-back: fifo holds 8'h00, 8'hFF -> exactly 2 rd_en pulses; 2-cycle idle-high gap between frames; second payload all ones; total 202 cycles from first start to second stop end.
- Registered-dout check: fifo model changes dout only on the edge after rd_en -> sampled serial payload equals the popped byte, never the stale value; sweep 16 random bytes with scoreboard.
- Reset mid-frame: assert rst at bit 4 of 8'h3C -> serial_out=1 the next cycle; after release with fifo_empty=1 no further rd_en and the line stays idle.
- Empty during frame: fifo_empty goes 1 immediately after the pop -> current frame completes intact; no rd_en issued in IDLE afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, default payload width.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} uart_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the wrap.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)        r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + 1'b1;
  end

  assign bit_done = en && (r_cnt == LAST);
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from a registered-output fifo and
// serialises them LSB-first; one read outstanding at most.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  tx_busy
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_t           r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_serial, w_serial_nxt;
  logic                  w_baud_en, w_bit_done;

  // Timer only runs while a bit is on the line, so it sits at 0 in IDLE/FETCH.
  assign w_baud_en = (r_state == START) || (r_state == DATA) || (r_state == STOP);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (w_baud_en),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_serial  <= IDLE_LEVEL;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_serial  <= w_serial_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      IDLE:  if (!fifo_empty) w_state_nxt = FETCH;
      // fifo_dout becomes valid the cycle after rd_en, i.e. here.
      FETCH: begin
        w_shift_nxt   = fifo_dout;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = START;
      end
      START: if (w_bit_done) w_state_nxt = DATA;
      DATA:  if (w_bit_done) begin
        w_shift_nxt   = r_shift >> 1;
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
      end
      STOP:  if (w_bit_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is registered from the next state so each bit holds for exactly one period.
  always_comb begin
    w_serial_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:   w_serial_nxt = START_BIT;
      DATA:    w_serial_nxt = w_shift_nxt[0];
      STOP:    w_serial_nxt = STOP_BIT;
      default: w_serial_nxt = IDLE_LEVEL;
    endcase
  end

  assign fifo_rd_en = !rst && (r_state == IDLE) && !fifo_empty;
  assign tx_busy    = !rst && (r_state != IDLE);
  assign serial_out = r_serial;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a registered-read fifo model (CLKS_PER_BIT=10).
module tb_uart_tx_fifo_drain;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int viol   = 0;
  int cyc    = 0;

  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.CLOCK_FREQ(100), .BAUD_RATE(10), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .tx_busy    (tx_busy)
  );

  // fifo model: dout updates only on the edge that accepts rd_en
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) viol <= viol + 1;
      else begin
        fifo_dout <= mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Count negedges until the start bit appears; expected latency/gap is 2.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (serial_out !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 2);
  endtask

  // Entered on the first start-bit cycle; checks all 100 frame cycles, returns on cycle 100.
  task automatic chk_frame(input string tag, input logic [7:0] b);
    logic [9:0] f;
    logic [7:0] got;
    int err;
    f = {1'b1, b, 1'b0};
    got = 8'h00;
    err = 0;
    for (int c = 0; c < 100; c++) begin
      if (serial_out !== f[c / 10] || tx_busy !== 1'b1) err++;
      if (c % 10 == 5 && c >= 10 && c < 90) got[c / 10 - 1] = serial_out;
      @(negedge clk);
    end
    chk({tag, " byte"}, {24'h0, got}, {24'h0, b});
    chk({tag, " cyc"}, err, 0);
  endtask

  task automatic idle_for(input string tag, input int n);
    int e;
    e = 0;
    repeat (n) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || fifo_rd_en !== 1'b0) e++;
    end
    chk(tag, e, 0);
  endtask

  initial begin
    int rd0, t0;
    logic [7:0] sb [16];
    logic [7:0] prev, b;

    // reset with fifo empty
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst out", {29'h0, serial_out, fifo_rd_en, tx_busy}, 32'b100);
    end
    rst = 1'b0;
    idle_for("idle after rst", 50);
    chk("idle rd", rd_cnt, 0);

    // single byte A5: line 0,1,0,1,0,0,1,0,1,1
    rd0 = rd_cnt;
    push(8'hA5);
    wait_start("a5 lat");
    chk_frame("a5", 8'hA5);
    chk("a5 busy end", {31'h0, tx_busy}, 0);
    chk("a5 line end", {31'h0, serial_out}, 1);
    chk("a5 rd", rd_cnt - rd0, 1);

    // back-to-back 00 then FF
    rd0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    wait_start("b2b lat");
    t0 = cyc;
    chk_frame("b2b0", 8'h00);
    wait_start("b2b gap");
    chk_frame("b2b1", 8'hFF);
    chk("b2b len", cyc - t0, 202);
    chk("b2b busy end", {31'h0, tx_busy}, 0);
    chk("b2b rd", rd_cnt - rd0, 2);

    // 16 random bytes, each different from the stale dout value
    prev = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == prev) b = b ^ 8'h01;
      sb[i] = b;
      prev = b;
    end
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) push(sb[i]);
    for (int i = 0; i < 16; i++) begin
      wait_start($sformatf("rnd%0d lat", i));
      chk_frame($sformatf("rnd%0d", i), sb[i]);
    end
    chk("rnd rd", rd_cnt - rd0, 16);

    // reset during data bit 4 of 3C
    rd0 = rd_cnt;
    push(8'h3C);
    wait_start("3c lat");
    repeat (55) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out", {29'h0, serial_out, fifo_rd_en, tx_busy}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    idle_for("midrst idle", 50);
    chk("midrst rd", rd_cnt - rd0, 1);

    // fifo goes empty right after the pop
    rd0 = rd_cnt;
    push(8'hC3);
    wait_start("c3 lat");
    chk_frame("c3", 8'hC3);
    idle_for("c3 idle", 30);
    chk("c3 rd", rd_cnt - rd0, 1);

    chk("rd while empty", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
